commit_unit: RTL

//  In-order retirement stage behind the instruction buffer. Walks the buffer from the

---
 rtl/r2rv_pkg.sv | 34 +++
 rtl/commit_select.sv | 39 +++
 rtl/commit_unit.sv | 104 ++++++++++
 3 files changed

// File: rtl/r2rv_pkg.sv
// Shared instruction-buffer types: geometry, entry lifecycle states and the entry record.
// Imported by both the buffer and the commit unit so they agree on layout.
package r2rv_pkg;

  localparam int unsigned BUF_SIZE_LOG = 4;
  localparam int unsigned BUF_SIZE     = 2 ** BUF_SIZE_LOG;
  localparam int unsigned SPEC_TAG_W   = 6;
  localparam int unsigned TAG_W        = 6;

  // Pointers carry one extra wrap bit so a full buffer differs from an empty one.
  typedef logic [BUF_SIZE_LOG:0]   ptr_t;
  typedef logic [BUF_SIZE_LOG-1:0] idx_t;

  typedef enum logic [2:0] {
    S_NOT_USED       = 3'd0,
    S_NOT_EXECUTED   = 3'd1,
    S_EXECUTING      = 3'd2,
    S_ADDR_GENERATED = 3'd3,
    S_EXECUTED       = 3'd4
  } e_state_t;

  typedef struct packed {
    e_state_t              e_state;
    logic [SPEC_TAG_W-1:0] speculative_tag;
    logic [TAG_W-1:0]      tag;
    logic [4:0]            Dest;
    logic [31:0]           result;
  } entry_t;

  function automatic idx_t slot_index(input ptr_t head, input int unsigned k);
    return idx_t'(head[BUF_SIZE_LOG-1:0] + idx_t'(k));
  endfunction

endpackage

// File: rtl/commit_select.sv
// Combinational retirement selection: finds the oldest run of executed, non-speculative
// entries starting at head, capped at COMMIT_WIDTH and at the buffer occupancy.
module commit_select
  import r2rv_pkg::*;
#(
  parameter int unsigned COMMIT_WIDTH = 2
) (
  input  entry_t                  entries [BUF_SIZE],
  input  ptr_t                    head,
  input  ptr_t                    tail,
  input  logic                    stall,
  output logic [COMMIT_WIDTH-1:0] eligible,
  output idx_t                    slot_idx [COMMIT_WIDTH],
  output logic [2:0]              n
);

  ptr_t                  occupancy;
  logic [COMMIT_WIDTH:0] chain;

  assign occupancy = tail - head;

  // chain[k+1] means slots 0..k all retire; one blocked slot stops every younger slot.
  always_comb begin
    chain    = '0;
    chain[0] = ~stall;
    n        = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      slot_idx[k] = slot_index(head, unsigned'(k));
      chain[k+1]  = chain[k] && (ptr_t'(k) < occupancy)
                    && (entries[slot_idx[k]].e_state == S_EXECUTED)
                    && (entries[slot_idx[k]].speculative_tag == '0);
      if (chain[k+1]) begin
        n = n + 3'd1;
      end
    end
    eligible = chain[COMMIT_WIDTH:1];
  end

endmodule

// File: rtl/commit_unit.sv
// In-order retirement stage: registers up to COMMIT_WIDTH retirements per cycle,
// advances head, issues register-file writes and frees the retired buffer slots.
module commit_unit
  import r2rv_pkg::*;
#(
  parameter int unsigned COMMIT_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  entry_t                       entries [BUF_SIZE],
  input  ptr_t                         tail,
  input  logic                         stall,
  output ptr_t                         head,
  output logic                         empty,
  output logic [COMMIT_WIDTH-1:0]      commit_valid,
  output logic [COMMIT_WIDTH-1:0]      rf_we,
  output logic [COMMIT_WIDTH-1:0][4:0] rf_waddr,
  output logic [COMMIT_WIDTH-1:0][31:0] rf_wdata,
  output logic [BUF_SIZE-1:0]          free_mask,
  output logic [31:0]                  retired_cnt,
  output logic                         order_err
);

  logic [COMMIT_WIDTH-1:0] eligible;
  idx_t                    slot_idx [COMMIT_WIDTH];
  logic [2:0]              n;

  ptr_t                          head_q, head_d;
  logic [COMMIT_WIDTH-1:0]       valid_q, valid_d;
  logic [COMMIT_WIDTH-1:0]       we_q, we_d;
  logic [COMMIT_WIDTH-1:0][4:0]  waddr_q, waddr_d;
  logic [COMMIT_WIDTH-1:0][31:0] wdata_q, wdata_d;
  logic [BUF_SIZE-1:0]           free_q, free_d;
  logic [31:0]                   cnt_q, cnt_d;
  logic                          err_q, err_d;

  commit_select #(
    .COMMIT_WIDTH(COMMIT_WIDTH)
  ) u_select (
    .entries (entries),
    .head    (head_q),
    .tail    (tail),
    .stall   (stall),
    .eligible(eligible),
    .slot_idx(slot_idx),
    .n       (n)
  );

  always_comb begin
    head_d  = head_q + ptr_t'(n);
    cnt_d   = cnt_q + 32'(n);
    valid_d = eligible;
    we_d    = '0;
    waddr_d = '0;
    wdata_d = '0;
    free_d  = '0;
    err_d   = err_q;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (eligible[k]) begin
        // x0 writes are dropped but the entry still retires.
        we_d[k]              = entries[slot_idx[k]].Dest != 5'd0;
        waddr_d[k]           = entries[slot_idx[k]].Dest;
        wdata_d[k]           = entries[slot_idx[k]].result;
        free_d[slot_idx[k]]  = 1'b1;
        if (entries[slot_idx[k]].tag[BUF_SIZE_LOG-1:0] != slot_idx[k]) begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q  <= '0;
      valid_q <= '0;
      we_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      free_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      valid_q <= valid_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      free_q  <= free_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign head         = head_q;
  assign empty        = (head_q == tail);
  assign commit_valid = valid_q;
  assign rf_we        = we_q;
  assign rf_waddr     = waddr_q;
  assign rf_wdata     = wdata_q;
  assign free_mask    = free_q;
  assign retired_cnt  = cnt_q;
  assign order_err    = err_q;

endmodule
